// File: rtl/outbox_fifo.sv
`default_nettype none
// ============================================================================
// Module      : outbox_fifo
// Description : First-word-fall-through output FIFO between the CPU and the
//               display/UART sink. Define OUTBOX_OVF_EN to build in the sticky
//               overflow flag; otherwise ovf is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module outbox_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  input  logic                     clr,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf
);

  localparam int                   c_AW       = $clog2(DEPTH);
  localparam logic [c_AW:0]        c_FULL_CNT = (c_AW+1)'(DEPTH);
  localparam logic [c_AW:0]        c_CNT_ONE  = (c_AW+1)'(1);
  localparam logic [c_AW-1:0]      c_PTR_ONE  = c_AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic             w_wr_ok;
  logic             w_rd_ok;

  assign full    = (r_count == c_FULL_CNT);
  assign o_valid = (r_count != '0);
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign count   = r_count;

  // A write while full is dropped even if a read frees a slot on the same edge.
  assign w_wr_ok = wr & ~full;
  assign w_rd_ok = o_valid & i_ready;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is deliberately unreset; a write coinciding with reset is suppressed.
  always_ff @(posedge clk) begin
    if (!i_rst && !clr && w_wr_ok) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

`ifdef OUTBOX_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_ovf <= 1'b0;
    end else if (clr) begin
      r_ovf <= 1'b0;
    end else if (wr && full) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_outbox_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_outbox_fifo
// Description : Self-checking bench for outbox_fifo against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_outbox_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             i_rst = 1'b0;
  logic             wr = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             clr = 1'b0;
  logic             i_ready = 1'b0;
  logic             full;
  logic [WIDTH-1:0] o_data;
  logic             o_valid;
  logic [4:0]       count;
  logic             ovf;

  int total = 0;
  int bad   = 0;

  outbox_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .i_rst(i_rst), .wr(wr), .din(din), .full(full), .clr(clr),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .count(count),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: the FIFO is just a bounded queue.
  logic [WIDTH-1:0] q[$];
  logic             m_ovf = 1'b0;
  logic [WIDTH-1:0] dut_log[$];

  always @(posedge clk or posedge i_rst) begin
    if (i_rst || clr) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      automatic bit do_rd = (q.size() != 0) && i_ready;
      automatic bit do_wr = wr && (q.size() < DEPTH);
      if (wr && q.size() == DEPTH) m_ovf = 1'b1;
      if (do_rd) void'(q.pop_front());
      if (do_wr) q.push_back(din);
    end
  end

  // Values the DUT hands downstream on each completed read.
  always @(posedge clk) begin
    if (!i_rst && !clr && o_valid && i_ready) dut_log.push_back(o_data);
  end

  function automatic logic exp_ovf();
`ifdef OUTBOX_OVF_EN
    return m_ovf;
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge clk) begin
    chk("count",   64'(count),   64'(q.size()));
    chk("o_valid", 64'(o_valid), 64'(q.size() != 0));
    chk("full",    64'(full),    64'(q.size() == DEPTH));
    chk("o_data",  64'(o_data),  64'((q.size() != 0) ? q[0] : 8'h00));
    chk("ovf",     64'(ovf),     64'(exp_ovf()));
  end

  // Called at a falling edge; inputs take effect at the next rising edge.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
    wr = w; din = d; i_ready = r; clr = c;
    @(negedge clk);
    wr = 1'b0; i_ready = 1'b0; clr = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_seq[$];
    #1 i_rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_data",  64'(o_data), 64'h0);
    chk("rst_ovf",   64'(ovf), 64'd0);
    i_rst = 1'b0;
    @(negedge clk);

    // Three writes held, then drained in order
    cyc(1, 8'h11, 0, 0); cyc(1, 8'h22, 0, 0); cyc(1, 8'h33, 0, 0);
    chk("t1_count", 64'(count), 64'd3);
    chk("t1_valid", 64'(o_valid), 64'd1);
    chk("t1_head",  64'(o_data), 64'h11);
    repeat (3) cyc(0, 8'h00, 1, 0);
    chk("t1_empty", 64'(o_valid), 64'd0);
    chk("t1_zero",  64'(o_data), 64'h00);
    chk("t1_nlog",  64'(dut_log.size()), 64'd3);
    if (dut_log.size() == 3) begin
      chk("t1_log0", 64'(dut_log[0]), 64'h11);
      chk("t1_log1", 64'(dut_log[1]), 64'h22);
      chk("t1_log2", 64'(dut_log[2]), 64'h33);
    end
    dut_log.delete();

    // Fill to DEPTH, drop a 17th write, drain
    for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0);
    chk("t2_full",  64'(full), 64'd1);
    chk("t2_count", 64'(count), 64'd16);
    cyc(1, 8'hAA, 0, 0);
    chk("t2_count17", 64'(count), 64'd16);
`ifdef OUTBOX_OVF_EN
    chk("t2_ovf", 64'(ovf), 64'd1);
`else
    chk("t2_ovf", 64'(ovf), 64'd0);
`endif
    for (int i = 0; i < 16; i++) cyc(0, 8'h00, 1, 0);
    chk("t2_nlog", 64'(dut_log.size()), 64'd16);
    for (int i = 0; i < 16 && i < dut_log.size(); i++) chk("t2_drain", 64'(dut_log[i]), 64'(i));
    dut_log.delete();
    cyc(0, 8'h00, 0, 1);

    // Full with simultaneous write and read: read completes, write dropped
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h40 + i), 0, 0);
    cyc(1, 8'hBB, 1, 0);
    chk("t3_count", 64'(count), 64'd15);
    chk("t3_full",  64'(full), 64'd0);
    chk("t3_head",  64'(o_data), 64'h41);
    cyc(0, 8'h00, 0, 1);
    dut_log.delete();

    // Streaming at count=5 for 40 cycles; pointers wrap twice
    for (int i = 0; i < 5; i++) begin
      cyc(1, 8'(8'h80 + i), 0, 0);
      exp_seq.push_back(8'(8'h80 + i));
    end
    for (int i = 0; i < 40; i++) begin
      cyc(1, 8'(8'h90 + i), 1, 0);
      exp_seq.push_back(8'(8'h90 + i));
    end
    chk("t4_count", 64'(count), 64'd5);
    chk("t4_nlog",  64'(dut_log.size()), 64'd40);
    for (int i = 0; i < 40 && i < dut_log.size(); i++) chk("t4_seq", 64'(dut_log[i]), 64'(exp_seq[i]));
    chk("t4_head", 64'(o_data), 64'hB3);
    dut_log.delete();
    cyc(0, 8'h00, 0, 1);

    // clr wins over a same-edge write
    for (int i = 0; i < 7; i++) cyc(1, 8'(8'hC0 + i), 0, 0);
    cyc(1, 8'hEE, 0, 1);
    chk("t5_count", 64'(count), 64'd0);
    chk("t5_valid", 64'(o_valid), 64'd0);
    chk("t5_ovf",   64'(ovf), 64'd0);
    cyc(1, 8'h5A, 0, 0);
    chk("t5_next",  64'(o_data), 64'h5A);
    chk("t5_cnt1",  64'(count), 64'd1);
    cyc(0, 8'h00, 0, 1);

    // Asynchronous reset between edges
    for (int i = 0; i < 4; i++) cyc(1, 8'(8'hD0 + i), 0, 0);
    chk("t6_pre", 64'(count), 64'd4);
    #2 i_rst = 1'b1;
    #1;
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_full",  64'(full), 64'd0);
    chk("t6_valid", 64'(o_valid), 64'd0);
    chk("t6_data",  64'(o_data), 64'h00);
    #1 i_rst = 1'b0;
    @(negedge clk);
    cyc(0, 8'h00, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
